// File: rtl/bram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter_pkg
// Description : Shared sizing helpers for the BRAM port arbiter and its
//               tag FIFO (ceiling log2, max, index/pointer widths).
// Revision    : 1.0 - initial release
// ============================================================================
package bram_port_arbiter_pkg;

    // Ceiling log2; 0 for n <= 1.
    function automatic int log2_ceil(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Width needed to index n items, never narrower than one bit.
    function automatic int idx_width_of(input int n);
        return max_int(1, log2_ceil(n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_port_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bram_tag_fifo
// Description : In-order FIFO holding the requester index of each in-flight
//               read. Push and pop may coincide, including when full.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_tag_fifo
    import bram_port_arbiter_pkg::*;
#(
    parameter int WIDTH     = 2,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = log2_ceil(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int                   PTR_WIDTH  = idx_width_of(DEPTH);
    localparam logic [PTR_WIDTH-1:0] C_LAST_PTR = PTR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] C_DEPTH    = CNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_push;
    logic                 w_pop;

    // A pop frees the slot the same-cycle push needs, so full only blocks a lone push.
    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != C_DEPTH) || w_pop);

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == C_DEPTH);
    assign empty    = (r_count == '0);
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Round-robin arbiter sharing one BRAM port among NUM_REQ
//               requesters, with optional grant lock, registered command
//               issue and in-order read-response routing.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH      = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int IDX_WIDTH       = idx_width_of(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    input  logic [NUM_REQ-1:0]               req_lock,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             bram_rden,
    output logic                             bram_wren,
    output logic [STRB_WIDTH-1:0]            bram_wrstrb,
    output logic [ADDR_WIDTH-1:0]            bram_addr,
    output logic [DATA_WIDTH-1:0]            bram_din,
    input  logic [DATA_WIDTH-1:0]            bram_dout,
    input  logic                             bram_dack,
    output logic                             err_unexp_dack
);

    localparam int                   CNT_WIDTH  = log2_ceil(MAX_OUTSTANDING + 1);
    localparam logic [IDX_WIDTH-1:0] C_LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

    logic [IDX_WIDTH-1:0]  r_rr_ptr;
    logic [IDX_WIDTH-1:0]  r_lock_idx;
    logic                  r_lock_valid;
    logic                  r_rden;
    logic                  r_wren;
    logic [STRB_WIDTH-1:0] r_wrstrb;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_err;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_WIDTH-1:0]  w_fifo_count;
    logic [IDX_WIDTH-1:0]  w_tag;
    logic                  w_pop;
    logic                  w_read_ok;
    logic [NUM_REQ-1:0]    w_eligible;
    logic                  w_accept;
    logic [IDX_WIDTH-1:0]  w_grant_idx;
    logic                  w_sel_we;
    logic [STRB_WIDTH-1:0] w_sel_strb;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // A dack that retires a read frees a slot for a read accepted in the same cycle.
    assign w_pop      = bram_dack && (w_fifo_count != '0);
    assign w_read_ok  = !w_fifo_full || w_pop;
    assign w_eligible = req_valid & (req_we | {NUM_REQ{w_read_ok}});

    // Grant selection: lock owner only, else first eligible after rr_ptr.
    always_comb begin
        logic [IDX_WIDTH-1:0] v_idx;
        int                   j;
        w_accept    = 1'b0;
        w_grant_idx = '0;
        v_idx       = '0;
        j           = 0;
        if (r_lock_valid) begin
            if (w_eligible[r_lock_idx]) begin
                w_accept    = 1'b1;
                w_grant_idx = r_lock_idx;
            end
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = int'(r_rr_ptr) + k;
                if (j >= NUM_REQ) j = j - NUM_REQ;
                v_idx = IDX_WIDTH'(j);
                if (!w_accept && w_eligible[v_idx]) begin
                    w_accept    = 1'b1;
                    w_grant_idx = v_idx;
                end
            end
        end
    end

    assign req_ready  = w_accept ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign w_sel_we   = req_we[w_grant_idx];
    assign w_sel_strb = req_strb[int'(w_grant_idx)*STRB_WIDTH +: STRB_WIDTH];
    assign w_sel_addr = req_addr[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_data = req_data[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    // Round-robin pointer and lock ownership.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr     <= C_LAST_IDX;
            r_lock_idx   <= '0;
            r_lock_valid <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr     <= w_grant_idx;
            r_lock_idx   <= w_grant_idx;
            r_lock_valid <= req_lock[w_grant_idx];
        end else if (r_lock_valid && (!req_valid[r_lock_idx] || !req_lock[r_lock_idx])) begin
            r_lock_valid <= 1'b0;
        end
    end

    // Command issue register: enables pulse for one cycle, payload holds otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rden   <= 1'b0;
            r_wren   <= 1'b0;
            r_wrstrb <= '0;
            r_addr   <= '0;
            r_din    <= '0;
        end else begin
            r_rden <= w_accept && !w_sel_we;
            r_wren <= w_accept && w_sel_we;
            if (w_accept) begin
                r_wrstrb <= w_sel_we ? w_sel_strb : '0;
                r_addr   <= w_sel_addr;
                r_din    <= w_sel_data;
            end
        end
    end

    // Sticky flag for a dack that has no read to retire.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                          r_err <= 1'b0;
        else if (bram_dack && w_fifo_empty) r_err <= 1'b1;
    end

    bram_tag_fifo #(
        .WIDTH     (IDX_WIDTH),
        .DEPTH     (MAX_OUTSTANDING),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_accept && !w_sel_we),
        .push_data (w_grant_idx),
        .pop       (bram_dack),
        .pop_data  (w_tag),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign rsp_valid      = w_pop ? (NUM_REQ'(1) << w_tag) : '0;
    assign rsp_data       = w_pop ? bram_dout : '0;
    assign bram_rden      = r_rden;
    assign bram_wren      = r_wren;
    assign bram_wrstrb    = r_wrstrb;
    assign bram_addr      = r_addr;
    assign bram_din       = r_din;
    assign err_unexp_dack = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Directed scoreboard bench for bram_port_arbiter. Stimulus
//               pushes expected grants, BRAM commands and read responses;
//               a negedge monitor pops and compares whenever they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int AW = 8;
    localparam int MO = 4;

    typedef struct {
        logic          wr;
        logic [SW-1:0] strb;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          chk_din;
    } cmd_t;

    typedef struct {
        logic [NR-1:0] vld;
        logic [DW-1:0] data;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_we = '0;
    logic [NR*SW-1:0] req_strb = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]    req_lock = '0;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             bram_rden;
    logic             bram_wren;
    logic [SW-1:0]    bram_wrstrb;
    logic [AW-1:0]    bram_addr;
    logic [DW-1:0]    bram_din;
    logic [DW-1:0]    bram_dout = '0;
    logic             bram_dack = 1'b0;
    logic             err_unexp_dack;

    cmd_t          exp_cmd_q [$];
    rsp_t          exp_rsp_q [$];
    logic [NR-1:0] exp_gnt_q [$];
    int            checks = 0;
    int            errors = 0;

    bram_port_arbiter #(
        .NUM_REQ         (NR),
        .DATA_WIDTH      (DW),
        .STRB_WIDTH      (SW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_strb       (req_strb),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_lock       (req_lock),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .bram_rden      (bram_rden),
        .bram_wren      (bram_wren),
        .bram_wrstrb    (bram_wrstrb),
        .bram_addr      (bram_addr),
        .bram_din       (bram_din),
        .bram_dout      (bram_dout),
        .bram_dack      (bram_dack),
        .err_unexp_dack (err_unexp_dack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic [SW-1:0] strb,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic lock);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_strb[i*SW +: SW] = strb;
        req_addr[i*AW +: AW] = addr;
        req_data[i*DW +: DW] = data;
        req_lock[i]          = lock;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic exp_read(input int i, input logic [AW-1:0] addr);
        exp_gnt_q.push_back(onehot(i));
        exp_cmd_q.push_back('{wr: 1'b0, strb: '0, addr: addr, din: '0, chk_din: 1'b0});
    endtask

    task automatic exp_write(input int i, input logic [SW-1:0] strb, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data);
        exp_gnt_q.push_back(onehot(i));
        exp_cmd_q.push_back('{wr: 1'b1, strb: strb, addr: addr, din: data, chk_din: 1'b1});
    endtask

    task automatic dack(input logic [DW-1:0] data, input int owner);
        bram_dack = 1'b1;
        bram_dout = data;
        exp_rsp_q.push_back('{vld: onehot(owner), data: data});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},   32'(req_ready),      32'd0);
        check({tag, "_rsp_valid"},   32'(rsp_valid),      32'd0);
        check({tag, "_bram_rden"},   32'(bram_rden),      32'd0);
        check({tag, "_bram_wren"},   32'(bram_wren),      32'd0);
        check({tag, "_bram_wrstrb"}, 32'(bram_wrstrb),    32'd0);
        check({tag, "_bram_addr"},   32'(bram_addr),      32'd0);
        check({tag, "_bram_din"},    32'(bram_din),       32'd0);
        check({tag, "_err"},         32'(err_unexp_dack), 32'd0);
    endtask

    task automatic do_reset();
        clear_reqs();
        bram_dack = 1'b0;
        bram_dout = '0;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Requester 2 reads 0x10; dack two cycles after acceptance returns d.
    task automatic single_read(input logic [DW-1:0] d);
        tick();
        set_req(2, 1'b1, 1'b0, 2'b11, 8'h10, 16'h0, 1'b0);
        exp_read(2, 8'h10);
        tick();
        set_req(2, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        tick();
        dack(d, 2);
        tick();
        bram_dack = 1'b0;
        bram_dout = '0;
    endtask

    // Monitor: compare every grant, BRAM command and response against the queues.
    initial begin
        cmd_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (req_ready != '0) begin
                if (exp_gnt_q.size() == 0) check("grant_unexpected", 32'(req_ready), 32'd0);
                else                       check("grant", 32'(req_ready), 32'(exp_gnt_q.pop_front()));
            end
            if (bram_rden || bram_wren) begin
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_unexpected", 32'({bram_rden, bram_wren}), 32'd0);
                end else begin
                    e = exp_cmd_q.pop_front();
                    check("cmd_rden",   32'(bram_rden),   32'(!e.wr));
                    check("cmd_wren",   32'(bram_wren),   32'(e.wr));
                    check("cmd_wrstrb", 32'(bram_wrstrb), 32'(e.strb));
                    check("cmd_addr",   32'(bram_addr),   32'(e.addr));
                    if (e.chk_din) check("cmd_din", 32'(bram_din), 32'(e.din));
                end
            end
            if (rsp_valid != '0) begin
                if (exp_rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    r = exp_rsp_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(r.vld));
                    check("rsp_data",  32'(rsp_data),  32'(r.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        // Reset state.
        #1 rstn = 1'b0;
        #2 check_all_zero("reset");
        tick();
        tick();
        rstn = 1'b1;

        // Single read.
        single_read(16'hBEEF);

        // Four requesters streaming reads, dack one cycle after issue.
        do_reset();
        tick();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, '0, 8'(8'h20 + i), '0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c < 8) exp_read(c % NR, 8'(8'h20 + (c % NR)));
            if (c == 8) clear_reqs();
            if (c >= 2) dack(16'(16'hA000 + c - 2), (c - 2) % NR);
            else        bram_dack = 1'b0;
            tick();
        end
        bram_dack = 1'b0;

        // Backpressure: four reads fill the tag FIFO, a write still passes.
        do_reset();
        tick();
        for (int c = 0; c < 4; c++) begin
            set_req(0, 1'b1, 1'b0, '0, 8'(8'h30 + c), '0, 1'b0);
            exp_read(0, 8'(8'h30 + c));
            tick();
        end
        set_req(0, 1'b1, 1'b0, '0, 8'h34, '0, 1'b0);
        set_req(1, 1'b1, 1'b1, 2'b11, 8'h40, 16'h1234, 1'b0);
        exp_write(1, 2'b11, 8'h40, 16'h1234);
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        #2 check("bp_read_blocked", 32'(req_ready), 32'd0);
        tick();
        dack(16'h5501, 0);
        exp_read(0, 8'h34);
        tick();
        clear_reqs();
        for (int k = 0; k < 4; k++) begin
            dack(16'(16'h5502 + k), 0);
            tick();
        end
        bram_dack = 1'b0;

        // Lock: requester 3 keeps the grant for three reads.
        do_reset();
        tick();
        set_req(2, 1'b1, 1'b1, 2'b01, 8'h70, 16'h00AA, 1'b0);
        exp_write(2, 2'b01, 8'h70, 16'h00AA);
        tick();
        set_req(0, 1'b1, 1'b1, 2'b11, 8'h50, 16'h1110, 1'b0);
        set_req(1, 1'b1, 1'b1, 2'b11, 8'h51, 16'h2220, 1'b0);
        set_req(2, 1'b1, 1'b1, 2'b11, 8'h52, 16'h3330, 1'b0);
        for (int k = 0; k < 3; k++) begin
            set_req(3, 1'b1, 1'b0, '0, 8'(8'h60 + k), '0, 1'b1);
            exp_read(3, 8'(8'h60 + k));
            tick();
        end
        set_req(3, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        #2 check("lock_release_cycle", 32'(req_ready), 32'd0);
        tick();
        exp_write(0, 2'b11, 8'h50, 16'h1110);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        exp_write(1, 2'b11, 8'h51, 16'h2220);
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        exp_write(2, 2'b11, 8'h52, 16'h3330);
        tick();
        clear_reqs();
        for (int k = 0; k < 3; k++) begin
            dack(16'(16'hC000 + k), 3);
            tick();
        end
        bram_dack = 1'b0;

        // Unexpected dack.
        do_reset();
        tick();
        #2 check("err_before", 32'(err_unexp_dack), 32'd0);
        bram_dack = 1'b1;
        bram_dout = 16'h7777;
        #2 check("err_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        bram_dack = 1'b0;
        #2 check("err_set", 32'(err_unexp_dack), 32'd1);
        tick();
        tick();
        #2 check("err_sticky", 32'(err_unexp_dack), 32'd1);

        // Reset with two reads in flight.
        do_reset();
        tick();
        set_req(0, 1'b1, 1'b0, '0, 8'h80, '0, 1'b0);
        exp_read(0, 8'h80);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        set_req(1, 1'b1, 1'b0, '0, 8'h81, '0, 1'b0);
        exp_gnt_q.push_back(onehot(1));
        tick();
        clear_reqs();
        rstn = 1'b0;
        #2 check_all_zero("midreset");
        tick();
        rstn = 1'b1;
        single_read(16'hBEE1);
        tick();
        bram_dack = 1'b1;
        bram_dout = 16'h9999;
        #2 check("stale_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        bram_dack = 1'b0;
        #2 check("stale_err", 32'(err_unexp_dack), 32'd1);

        tick();
        tick();
        check("gnt_q_drained", 32'(exp_gnt_q.size()), 32'd0);
        check("cmd_q_drained", 32'(exp_cmd_q.size()), 32'd0);
        check("rsp_q_drained", 32'(exp_rsp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
